// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// Holds the FSM state enum, command field values and response bytes.
package tour_pkg;

  localparam int DEFAULT_NUM_MOVES = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    VWAIT = 3'd2,
    HORZ  = 3'd3,
    HWAIT = 3'd4
  } tour_state_e;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/move_decoder.sv
// Turns a one-hot knight move into its vertical and horizontal commands.
// Multi-hot inputs resolve to the lowest set bit; all-zero reports invalid.
module move_decoder
  import tour_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o,
  output logic        valid_o
);

  logic [2:0] sel;
  logic       dx_pos;
  logic       dy_pos;
  logic [3:0] dx_mag;
  logic [3:0] dy_mag;

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (move_i[i]) sel = 3'(i);
    end
  end

  always_comb begin
    dx_pos = 1'b1;
    dy_pos = 1'b1;
    dx_mag = 4'd1;
    dy_mag = 4'd2;
    unique case (sel)
      3'd0: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      3'd1: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      3'd2: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      3'd3: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      3'd4: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      3'd5: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      3'd6: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      3'd7: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      default: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
    endcase
  end

  assign vert_cmd_o = make_cmd(OP_MOVE, dy_pos ? HDG_NORTH : HDG_SOUTH, dy_mag);
  assign horz_cmd_o = make_cmd(OP_FANFARE, dx_pos ? HDG_EAST : HDG_WEST, dx_mag);
  assign valid_o    = |move_i;

endmodule

// File: rtl/tour_cmd_seq.sv
// Sequences a solved knight tour into move commands for cmd_proc, and
// passes remote UART commands straight through whenever no tour is running.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = DEFAULT_NUM_MOVES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_e state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        mv_valid;
  logic        last_move;

  move_decoder u_move_decoder (
    .move_i     (move),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd),
    .valid_o    (mv_valid)
  );

  assign last_move = (mv_indx_q == LAST_IDX);
  assign mv_indx   = mv_indx_q;

  // start_tour wins from any state so the tour logic can always restart cleanly.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    if (start_tour) begin
      state_d   = VERT;
      mv_indx_d = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        VERT: begin
          if (!mv_valid)        state_d = IDLE;
          else if (clr_cmd_rdy) state_d = VWAIT;
        end
        VWAIT: if (send_resp)   state_d = HORZ;
        HORZ:  if (clr_cmd_rdy) state_d = HWAIT;
        HWAIT: begin
          if (send_resp) begin
            if (last_move) begin
              state_d = IDLE;
            end else begin
              state_d   = VERT;
              mv_indx_d = mv_indx_q + 5'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // While touring, UART traffic is held off by never acknowledging it.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = RESP_DONE;
    unique case (state_q)
      IDLE: ;
      VERT: begin
        cmd = vert_cmd; cmd_rdy = 1'b1; clr_cmd_rdy_UART = 1'b0; resp = RESP_BUSY;
      end
      VWAIT: begin
        cmd = vert_cmd; cmd_rdy = 1'b0; clr_cmd_rdy_UART = 1'b0; resp = RESP_BUSY;
      end
      HORZ: begin
        cmd = horz_cmd; cmd_rdy = 1'b1; clr_cmd_rdy_UART = 1'b0; resp = RESP_BUSY;
      end
      HWAIT: begin
        cmd = horz_cmd; cmd_rdy = 1'b0; clr_cmd_rdy_UART = 1'b0;
        resp = last_move ? RESP_DONE : RESP_BUSY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Randomized self-checking bench for tour_cmd_seq against a move-table model.
module tb_tour_cmd_seq;

  localparam int N = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  moveTable [32];
  logic        useTable;
  logic [7:0]  moveForce;

  int compared = 0;
  int mismatched = 0;

  int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  always_comb move = useTable ? moveTable[mv_indx] : moveForce;

  tour_cmd_seq #(.NUM_MOVES(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  function automatic int lowBit(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] modelVert(input logic [7:0] m);
    int dy;
    logic [3:0] sq;
    dy = DY[lowBit(m)];
    sq = 4'((dy < 0) ? -dy : dy);
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, sq};
  endfunction

  function automatic logic [15:0] modelHorz(input logic [7:0] m);
    int dx;
    logic [3:0] sq;
    dx = DX[lowBit(m)];
    sq = 4'((dx < 0) ? -dx : dx);
    return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, sq};
  endfunction

  function automatic logic [7:0] randomMove();
    logic [7:0] m;
    if ($urandom_range(0, 1) == 0) begin
      m = 8'h01 << $urandom_range(0, 7);
    end else begin
      m = 8'($urandom);
      if (m == 8'h00) m = 8'h80;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    useTable = 1'b0; moveForce = 8'h01;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic startTour();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  task automatic fillTable();
    for (int i = 0; i < 32; i++) moveTable[i] = randomMove();
  endtask

  // Walks one move through VERT/VWAIT/HORZ/HWAIT with random stalls and ignored strobes.
  task automatic driveMove(input int k);
    logic [15:0] ev, eh;
    logic [7:0]  lastResp;
    ev = modelVert(moveTable[k]);
    eh = modelHorz(moveTable[k]);
    lastResp = (k == N - 1) ? 8'hA5 : 8'h5A;
    for (int ph = 0; ph < 2; ph++) begin
      logic [15:0] ec;
      ec = (ph == 0) ? ev : eh;
      repeat ($urandom_range(0, 2)) begin
        send_resp = 1'($urandom_range(0, 1)); clr_cmd_rdy = 1'b0; #1;
        compared++;
        if (cmd !== ec || cmd_rdy !== 1'b1 || mv_indx !== 5'(k) || resp !== 8'h5A || clr_cmd_rdy_UART !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL issue_hold k=%0d ph=%0d: cmd=%h rdy=%b idx=%0d resp=%h clrU=%b, want cmd=%h rdy=1 idx=%0d resp=5a clrU=0",
                   k, ph, cmd, cmd_rdy, mv_indx, resp, clr_cmd_rdy_UART, ec, k);
        end
        step();
      end
      send_resp = 1'b0; clr_cmd_rdy = 1'b1; #1;
      compared++;
      if (cmd !== ec || cmd_rdy !== 1'b1 || mv_indx !== 5'(k) || clr_cmd_rdy_UART !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL issue_accept k=%0d ph=%0d: cmd=%h rdy=%b idx=%0d clrU=%b, want cmd=%h rdy=1 idx=%0d clrU=0",
                 k, ph, cmd, cmd_rdy, mv_indx, clr_cmd_rdy_UART, ec, k);
      end
      step();
      clr_cmd_rdy = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        clr_cmd_rdy = 1'($urandom_range(0, 1)); #1;
        compared++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'(k) || resp !== ((ph == 1) ? lastResp : 8'h5A) || clr_cmd_rdy_UART !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL wait_hold k=%0d ph=%0d: rdy=%b idx=%0d resp=%h clrU=%b, want rdy=0 idx=%0d resp=%h clrU=0",
                   k, ph, cmd_rdy, mv_indx, resp, clr_cmd_rdy_UART, k, (ph == 1) ? lastResp : 8'h5A);
        end
        step();
      end
      clr_cmd_rdy = 1'b0; send_resp = 1'b1; #1;
      compared++;
      if (cmd_rdy !== 1'b0 || resp !== ((ph == 1) ? lastResp : 8'h5A)) begin
        mismatched++;
        $display("[TB] FAIL wait_done k=%0d ph=%0d: rdy=%b resp=%h, want rdy=0 resp=%h",
                 k, ph, cmd_rdy, resp, (ph == 1) ? lastResp : 8'h5A);
      end
      step();
      send_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_tour = 1'b0; send_resp = 1'b0; useTable = 1'b0; moveForce = 8'h01;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b0 || clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5 || mv_indx !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: cmd=%h rdy=%b clrU=%b resp=%h idx=%0d, want 1234/0/1/a5/0",
               cmd, cmd_rdy, clr_cmd_rdy_UART, resp, mv_indx);
    end
    clr_cmd_rdy = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_passthrough();
    cmd_UART = 16'h2002; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b0; #1;
    compared++;
    if (cmd !== 16'h2002 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL idle_2002: cmd=%h rdy=%b resp=%h, want 2002/1/a5", cmd, cmd_rdy, resp);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      cmd_UART = 16'($urandom); cmd_rdy_UART = 1'($urandom_range(0, 1));
      clr_cmd_rdy = 1'($urandom_range(0, 1)); #1;
      compared++;
      if (cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART || clr_cmd_rdy_UART !== clr_cmd_rdy || resp !== 8'hA5) begin
        mismatched++;
        $display("[TB] FAIL idle_pass: cmd=%h rdy=%b clrU=%b resp=%h, want %h/%b/%b/a5",
                 cmd, cmd_rdy, clr_cmd_rdy_UART, resp, cmd_UART, cmd_rdy_UART, clr_cmd_rdy);
      end
      step();
    end
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_first_move();
    doReset();
    useTable = 1'b0; moveForce = 8'h04;
    startTour();
    #1;
    compared++;
    if (cmd !== 16'h2001 || cmd_rdy !== 1'b1 || resp !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL first_vert: cmd=%h rdy=%b resp=%h, want 2001/1/5a", cmd, cmd_rdy, resp);
    end
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0; #1;
    compared++;
    if (cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL first_vwait: rdy=%b resp=%h, want 0/5a", cmd_rdy, resp);
    end
    send_resp = 1'b1; step(); send_resp = 1'b0; #1;
    compared++;
    if (cmd !== 16'h33F2 || cmd_rdy !== 1'b1 || resp !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL first_horz: cmd=%h rdy=%b resp=%h, want 33f2/1/5a", cmd, cmd_rdy, resp);
    end
  endtask

  task automatic test_full_tour();
    doReset();
    fillTable();
    useTable = 1'b1;
    cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1;
    startTour();
    for (int k = 0; k < N; k++) driveMove(k);
    clr_cmd_rdy = 1'b1; #1;
    compared++;
    if (cmd_rdy !== 1'b1 || cmd !== cmd_UART || clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL tour_end_idle: cmd=%h rdy=%b clrU=%b resp=%h, want %h/1/1/a5",
               cmd, cmd_rdy, clr_cmd_rdy_UART, resp, cmd_UART);
    end
    step();
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_abort_and_restart();
    doReset();
    fillTable();
    moveTable[5] = 8'h00;
    useTable = 1'b1; cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b0;
    startTour();
    for (int k = 0; k < 5; k++) driveMove(k);
    #1;
    compared++;
    if (mv_indx !== 5'd5) begin
      mismatched++;
      $display("[TB] FAIL abort_idx: idx=%0d, want 5", mv_indx);
    end
    step();
    compared++;
    if (cmd_rdy !== 1'b0 || cmd !== cmd_UART || resp !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL abort_idle: cmd=%h rdy=%b resp=%h, want %h/0/a5", cmd, cmd_rdy, resp, cmd_UART);
    end
    moveTable[5] = randomMove();
    startTour();
    for (int k = 0; k < 5; k++) driveMove(k);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;   step(); send_resp = 1'b0;
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    #1;
    compared++;
    if (mv_indx !== 5'd5 || cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL hwait5: idx=%0d rdy=%b resp=%h, want 5/0/5a", mv_indx, cmd_rdy, resp);
    end
    startTour();
    #1;
    compared++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== modelVert(moveTable[0])) begin
      mismatched++;
      $display("[TB] FAIL restart: idx=%0d rdy=%b cmd=%h, want 0/1/%h", mv_indx, cmd_rdy, cmd, modelVert(moveTable[0]));
    end
  endtask

  task automatic test_reset_midtour();
    doReset();
    fillTable();
    useTable = 1'b1; cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b0;
    startTour();
    for (int k = 0; k < 3; k++) driveMove(k);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || cmd !== cmd_UART || resp !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL async_reset: idx=%0d rdy=%b cmd=%h resp=%h, want 0/0/%h/a5", mv_indx, cmd_rdy, cmd, resp, cmd_UART);
    end
    #1 rst_n = 1'b1;
    step();
    compared++;
    if (cmd_rdy !== 1'b0 || resp !== 8'hA5 || mv_indx !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: rdy=%b resp=%h idx=%0d, want 0/a5/0", cmd_rdy, resp, mv_indx);
    end
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_first_move();
    test_full_tour();
    test_abort_and_restart();
    test_reset_midtour();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
